sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between two requesters: the video
//  scanline fetcher (burst reads, port V) and the CPU bus (single-word
//  read/write, port C). Video has priority. A starvation counter guarantees
//  the CPU a slot. Sits between the video/CPU blocks and the SDRAM controller.
// PARAMETERS
//  ADDR_W        32  address width, all ports
//  DATA_W        16  data width, all ports
//  STARVE_LIMIT  4   consecutive video grants while CPU waits before CPU is forced
//  TIMEOUT       255 cycles without mem_rvalid/mem_wdone before a transfer aborts
// PORTS
//  clk            in   1       system clock
//  reset          in   1       async, active-low
//  vid_req        in   1       level; video burst request, held until vid_done
//  vid_addr       in   ADDR_W  burst start address, stable while vid_req=1
//  vid_burst_len  in   8       words-1 (31 => 32 words)
//  vid_grant      out  1       high from grant until burst end
//  vid_rdata      out  DATA_W  read word, valid with vid_rvalid
//  vid_rvalid     out  1       one pulse per returned word
//  vid_done       out  1       1-cycle pulse after last word or abort
//  cpu_req        in   1       level; single-word request, held until cpu_ready
//  cpu_we         in   1       1=write, 0=read
//  cpu_addr       in   ADDR_W  word address
//  cpu_wdata      in   DATA_W  write data
//  cpu_rdata      out  DATA_W  read data, valid with cpu_ready
//  cpu_ready      out  1       1-cycle completion pulse (read or write)
//  mem_req        out  1       level request to controller
//  mem_we         out  1       write enable
//  mem_addr       out  ADDR_W  transfer address
//  mem_burst_len  out  8       words-1; 0 for CPU transfers
//  mem_wdata      out  DATA_W  write data
//  mem_rdata      in   DATA_W  read data
//  mem_rvalid     in   1       per-word read strobe
//  mem_wdone      in   1       write-complete pulse
//  err_timeout    out  1       sticky; set on any abort, cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; every output 0;
//   starve_cnt=0; word_cnt=0; timer=0.
//  States: IDLE -> V_XFER | C_XFER -> RELEASE -> IDLE.
//  IDLE arbitration (one cycle):
//   - cpu_req && (!vid_req || starve_cnt==STARVE_LIMIT) -> C_XFER, starve_cnt<=0.
//   - else if vid_req -> V_XFER; starve_cnt<=starve_cnt+1 if cpu_req, else 0.
//   - Register vid_addr/vid_burst_len or cpu_addr/cpu_we/cpu_wdata on entry.
//     mem_* are driven from these registers only.
//  V_XFER: mem_req=1, mem_we=0, vid_grant=1. Each mem_rvalid: vid_rdata<=mem_rdata,
//   vid_rvalid pulses the next cycle, word_cnt++. When word_cnt==burst_len and
//   mem_rvalid: go to RELEASE, vid_done pulses on the following cycle.
//   Extra mem_rvalid after the last word is ignored.
//  C_XFER: mem_req=1, mem_burst_len=0.
//   - Read: first mem_rvalid -> cpu_rdata<=mem_rdata, cpu_ready pulse next cycle.
//   - Write: mem_wdone -> cpu_ready pulse next cycle.
//   - Then RELEASE.
//  RELEASE: mem_req=0, vid_grant=0 for exactly 1 cycle. This is the mandatory
//   deassert gap for the controller. Back-to-back grants are therefore >=1 cycle
//   apart.
//  Timeout: timer resets on entry to V_XFER/C_XFER and on every mem_rvalid/mem_wdone.
//   If timer reaches TIMEOUT: err_timeout<=1, go to RELEASE. Completion is still
//   signalled so requesters never hang:
//   - V: vid_done pulses.
//   - C: cpu_ready pulses, cpu_rdata=0.
//  Simultaneous vid_req and cpu_req with starve_cnt<STARVE_LIMIT: video wins.
//  Request dropped mid-transfer: ignored; the transfer completes.
//  starve_cnt saturates at STARVE_LIMIT. It clears only when the CPU is granted,
//   or when video is granted with cpu_req=0.
//  Reset mid-transfer: immediate return to reset values. The controller sees
//   mem_req fall asynchronously.
//  Latency: req high in IDLE -> mem_req high on the next clk edge.
// TESTING
//  1 Video only: vid_req, addr=0xC00400, len=31, 32 mem_rvalid -> 32 vid_rvalid,
//    1 vid_done, mem_req low 1 cycle after.
//  2 CPU read: addr=0x10, mem_rdata=0xBEEF -> cpu_rdata=0xBEEF with single
//    cpu_ready; mem_burst_len=0, mem_we=0.
//  3 Both req same cycle, starve_cnt=0 -> video granted first; CPU granted
//    immediately after the RELEASE cycle.
//  4 Video req held continuously + cpu_req -> 4 video bursts, then CPU forced
//    on the 5th arbitration.
//  5 CPU write, mem_wdone never arrives -> abort after 255 cycles;
//    err_timeout=1, cpu_ready pulses.
//  6 Assert reset mid-V_XFER (word 10) -> all outputs 0 asynchronously;
//    after release, a new burst completes all 32 words normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sdram_arbiter
// Brief    : Shares one SDRAM controller port between a video burst reader and
//            a CPU single-word port; video has priority, CPU has a starvation
//            guard, and every transfer is bounded by a watchdog timer.
// Revision : 1.0
// =============================================================================
module sdram_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   input  logic [7:0]        vid_burst_len,
   output logic              vid_grant,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_rvalid,
   output logic              vid_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_burst_len,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   input  logic              mem_wdone,
   output logic              err_timeout
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      V_XFER  = 2'd1,
      C_XFER  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     starve_cnt;
   logic [7:0]        word_cnt;
   logic [TW-1:0]     timer;
   logic [ADDR_W-1:0] xfer_addr;
   logic [7:0]        xfer_len;
   logic              xfer_we;
   logic [DATA_W-1:0] xfer_wdata;

   logic grant_cpu;
   logic grant_vid;
   logic strobe;
   logic timed_out;
   logic v_last;
   logic c_done;

   assign mem_req       = (state == V_XFER) || (state == C_XFER);
   assign vid_grant     = (state == V_XFER);
   assign mem_we        = xfer_we;
   assign mem_addr      = xfer_addr;
   assign mem_burst_len = xfer_len;
   assign mem_wdata     = xfer_wdata;

   always_comb begin
      grant_cpu = cpu_req && (!vid_req || (starve_cnt == STARVE_MAX));
      grant_vid = !grant_cpu && vid_req;
      strobe    = mem_rvalid || mem_wdone;
      // Abort on the edge that closes the TIMEOUT-th silent transfer cycle.
      timed_out = !strobe && (timer == TIMER_LAST);
      v_last    = mem_rvalid && (word_cnt == xfer_len);
      c_done    = xfer_we ? mem_wdone : mem_rvalid;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_cpu) begin
               state_nxt = C_XFER;
            end else if (grant_vid) begin
               state_nxt = V_XFER;
            end
         end
         V_XFER: begin
            if (v_last || timed_out) begin
               state_nxt = RELEASE;
            end
         end
         C_XFER: begin
            if (c_done || timed_out) begin
               state_nxt = RELEASE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt  <= '0;
         word_cnt    <= '0;
         timer       <= '0;
         xfer_addr   <= '0;
         xfer_len    <= '0;
         xfer_we     <= 1'b0;
         xfer_wdata  <= '0;
         vid_rdata   <= '0;
         vid_rvalid  <= 1'b0;
         vid_done    <= 1'b0;
         cpu_rdata   <= '0;
         cpu_ready   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         vid_rvalid <= 1'b0;
         vid_done   <= 1'b0;
         cpu_ready  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  starve_cnt <= '0;
                  timer      <= '0;
                  xfer_addr  <= cpu_addr;
                  xfer_len   <= 8'd0;
                  xfer_we    <= cpu_we;
                  xfer_wdata <= cpu_wdata;
               end else if (grant_vid) begin
                  if (!cpu_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt != STARVE_MAX) begin
                     starve_cnt <= starve_cnt + SW'(1);
                  end
                  timer     <= '0;
                  word_cnt  <= 8'd0;
                  xfer_addr <= vid_addr;
                  xfer_len  <= vid_burst_len;
                  xfer_we   <= 1'b0;
               end
            end
            V_XFER: begin
               timer <= strobe ? '0 : timer + TW'(1);
               if (mem_rvalid) begin
                  vid_rdata  <= mem_rdata;
                  vid_rvalid <= 1'b1;
                  word_cnt   <= word_cnt + 8'd1;
               end
               if (v_last || timed_out) begin
                  vid_done <= 1'b1;
               end
               if (timed_out) begin
                  err_timeout <= 1'b1;
               end
            end
            C_XFER: begin
               timer <= strobe ? '0 : timer + TW'(1);
               if (c_done) begin
                  cpu_ready <= 1'b1;
                  if (!xfer_we) begin
                     cpu_rdata <= mem_rdata;
                  end
               end
               if (timed_out) begin
                  cpu_ready   <= 1'b1;
                  cpu_rdata   <= '0;
                  err_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Directed and randomized bench for sdram_arbiter with a
//            transaction-level arbitration / data model.
// Revision : 1.0
// =============================================================================
module tb_sdram_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 16;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 255;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              vid_req = 1'b0;
   logic [ADDR_W-1:0] vid_addr = '0;
   logic [7:0]        vid_burst_len = '0;
   logic              vid_grant;
   logic [DATA_W-1:0] vid_rdata;
   logic              vid_rvalid;
   logic              vid_done;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_burst_len;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_rvalid = 1'b0;
   logic              mem_wdone = 1'b0;
   logic              err_timeout;
   logic [94:0]       all_out;

   sdram_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (STARVE_LIMIT),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .vid_req       (vid_req),
      .vid_addr      (vid_addr),
      .vid_burst_len (vid_burst_len),
      .vid_grant     (vid_grant),
      .vid_rdata     (vid_rdata),
      .vid_rvalid    (vid_rvalid),
      .vid_done      (vid_done),
      .cpu_req       (cpu_req),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .cpu_ready     (cpu_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_burst_len (mem_burst_len),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .mem_wdone     (mem_wdone),
      .err_timeout   (err_timeout)
   );

   assign all_out = {vid_grant, vid_rdata, vid_rvalid, vid_done, cpu_rdata, cpu_ready,
                     mem_req, mem_we, mem_addr, mem_burst_len, mem_wdata, err_timeout};

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Transaction-level model state.
   bit                vid_pend   = 1'b0;
   bit                cpu_pend   = 1'b0;
   bit                in_release = 1'b0;
   int                starve     = 0;
   logic [ADDR_W-1:0] v_addr     = '0;
   logic [7:0]        v_len      = '0;
   logic [ADDR_W-1:0] c_addr     = '0;
   logic              c_we       = 1'b0;
   logic [DATA_W-1:0] c_wdata    = '0;
   logic [DATA_W-1:0] c_resp     = '0;

   task automatic chk(input string tag, input logic [94:0] obs, input logic [94:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic raise_vid(input logic [ADDR_W-1:0] a, input logic [7:0] l);
      vid_pend = 1'b1;
      v_addr   = a;
      v_len    = l;
   endtask

   task automatic raise_cpu(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
      cpu_pend = 1'b1;
      c_we     = we;
      c_addr   = a;
      c_wdata  = wd;
      c_resp   = rd;
   endtask

   // Present pending requests, wait for the grant and check owner, latency and mem_* fields.
   task automatic arbitrate(output bit got_vid);
      bit pred_cpu;
      int exp_wait;
      int n;
      pred_cpu      = cpu_pend && (!vid_pend || starve == STARVE_LIMIT);
      exp_wait      = in_release ? 2 : 1;
      vid_req       = vid_pend;
      vid_addr      = v_addr;
      vid_burst_len = v_len;
      cpu_req       = cpu_pend;
      cpu_we        = c_we;
      cpu_addr      = c_addr;
      cpu_wdata     = c_wdata;
      if (in_release) begin
         mem_rdata  = DATA_W'($urandom);
         mem_rvalid = 1'b1;
      end
      n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
         if (n == 1) begin
            mem_rvalid = 1'b0;
            if (in_release) begin
               chk("stray_rvalid_ignored", vid_rvalid, 0);
               chk("pulses_single", {vid_done, cpu_ready}, 0);
            end
         end
      end
      chk("grant_latency", n, exp_wait);
      chk("grant_owner", vid_grant, !pred_cpu);
      if (pred_cpu) begin
         starve = 0;
         chk("cpu_mem_fields", {mem_addr, mem_burst_len, mem_we}, {c_addr, 8'd0, c_we});
         if (c_we) chk("cpu_wdata", mem_wdata, c_wdata);
      end else begin
         starve = cpu_pend ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
         chk("vid_mem_fields", {mem_addr, mem_burst_len, mem_we}, {v_addr, v_len, 1'b0});
      end
      got_vid    = !pred_cpu;
      in_release = 1'b0;
   endtask

   // Returns early after stop_at words when stop_at > 0.
   task automatic serve_video(input int stop_at);
      logic [DATA_W-1:0] d;
      bit last;
      for (int w = 0; w <= int'(v_len); w++) begin
         repeat ($urandom_range(0, 2)) tick();
         d          = DATA_W'($urandom);
         mem_rdata  = d;
         mem_rvalid = 1'b1;
         tick();
         mem_rvalid = 1'b0;
         last = (w == int'(v_len));
         chk("vid_word", {vid_rvalid, vid_rdata}, {1'b1, d});
         chk("vid_done", vid_done, last);
         chk("mem_req_during_burst", mem_req, !last);
         if (w + 1 == stop_at) return;
      end
      vid_pend   = 1'b0;
      in_release = 1'b1;
   endtask

   task automatic serve_cpu(input bit noresp);
      int n;
      if (noresp) begin
         n = 0;
         while (!cpu_ready && n < 400) begin
            tick();
            n++;
         end
         chk("timeout_cycles", n, TIMEOUT);
         chk("timeout_flags", {cpu_ready, err_timeout, cpu_rdata}, {1'b1, 1'b1, 16'h0});
      end else begin
         repeat ($urandom_range(0, 3)) tick();
         if (c_we) begin
            mem_wdone = 1'b1;
         end else begin
            mem_rdata  = c_resp;
            mem_rvalid = 1'b1;
         end
         tick();
         mem_wdone  = 1'b0;
         mem_rvalid = 1'b0;
         chk("cpu_ready", cpu_ready, 1);
         if (!c_we) chk("cpu_rdata", cpu_rdata, c_resp);
      end
      chk("mem_req_release", mem_req, 0);
      cpu_pend   = 1'b0;
      in_release = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      bit kind;
      int vid_run;

      #2 reset = 1'b0;
      #1 chk("reset_outputs", all_out, '0);
      tick();
      tick();
      chk("reset_held_outputs", all_out, '0);
      @(negedge clk);
      reset = 1'b1;

      // Video-only 32-word burst.
      raise_vid(32'h00C0_0400, 8'd31);
      arbitrate(got);
      serve_video(0);

      // CPU read.
      raise_cpu(1'b0, 32'h0000_0010, 16'h0, 16'hBEEF);
      arbitrate(got);
      serve_cpu(1'b0);

      // Simultaneous requests with starve count at zero: video then CPU.
      raise_vid(32'h0000_2000, 8'd3);
      raise_cpu(1'b1, 32'h0000_0020, 16'h1234, 16'h0);
      arbitrate(got);
      chk("both_req_video_first", got, 1);
      serve_video(0);
      arbitrate(got);
      chk("both_req_cpu_second", got, 0);
      serve_cpu(1'b0);

      // Video held continuously with CPU waiting: four bursts, then the CPU.
      raise_cpu(1'b0, 32'h0000_0030, 16'h0, 16'h5A5A);
      for (int k = 0; k < 5; k++) begin
         if (!vid_pend) raise_vid(32'h0001_0000 + 32'(k * 64), 8'd1);
         arbitrate(got);
         chk("starve_order", got, k < 4);
         if (got) serve_video(0);
         else serve_cpu(1'b0);
      end
      vid_pend = 1'b0;

      // CPU write with no completion: watchdog abort.
      chk("err_clear_before_abort", err_timeout, 0);
      raise_cpu(1'b1, 32'h0000_0040, 16'hCAFE, 16'h0);
      arbitrate(got);
      serve_cpu(1'b1);

      // Randomized mix of video and CPU traffic.
      for (int it = 0; it < 25; it++) begin
         if (!vid_pend && $urandom_range(0, 1) == 1)
            raise_vid($urandom, 8'($urandom_range(0, 7)));
         if (!cpu_pend && $urandom_range(0, 1) == 1)
            raise_cpu(1'($urandom), $urandom, DATA_W'($urandom), DATA_W'($urandom));
         if (!vid_pend && !cpu_pend)
            raise_cpu(1'b0, $urandom, DATA_W'($urandom), DATA_W'($urandom));
         arbitrate(got);
         if (got) serve_video(0);
         else serve_cpu(1'b0);
      end
      chk("err_sticky", err_timeout, 1);

      // Reset in the middle of a burst, then a clean burst.
      vid_run = 0;
      cpu_pend = 1'b0;
      raise_vid(32'h00C0_0800, 8'd31);
      arbitrate(kind);
      serve_video(10);
      #2 reset = 1'b0;
      #1 chk("reset_mid_burst", all_out, '0);
      vid_req    = 1'b0;
      cpu_req    = 1'b0;
      vid_pend   = 1'b0;
      in_release = 1'b0;
      starve     = 0;
      @(negedge clk);
      reset = 1'b1;
      raise_vid(32'h00C0_0400, 8'd31);
      arbitrate(got);
      serve_video(0);
      vid_run++;
      chk("post_reset_burst", {vid_run[0], err_timeout}, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
